pe_accum_sched: RTL and testbench

Scheduler and owner of the sparse-CNN output accumulator. It accepts a tile configuration, then consumes PE-array result bursts over a valid/ready handshake. Each burst holds PE_OUT lanes of product, column and row; the block serialises one lane per tclk into a 25-entry accumulation bank. After the configured number of bursts it drains the bank word-by-word to the downstream writer, then clears it for the next tile.

---
 rtl/pe_accum_sched_pkg.sv | 28 ++
 rtl/pe_accum_sched_if.sv | 34 +++
 rtl/pe_accum_sched_bank.sv | 34 +++
 rtl/pe_accum_sched.sv | 170 +++++++++++++++++
 tb/tb_pe_accum_sched.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_accum_sched_pkg.sv
// Shared constants, FSM state type and sizing helper for the sparse-CNN
// output accumulator scheduler.
package pe_accum_sched_pkg;

  localparam int WORD_W   = 16;
  localparam int COORD_W  = 8;
  localparam int PE_OUT   = 16;
  localparam int OUT_COLS = 5;
  localparam int OUT_SIZE = OUT_COLS * OUT_COLS;
  localparam int BURST_W  = 8;
  localparam int DROP_W   = 16;

  // Address width for an n-entry structure, never less than one bit.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ADDR_W = addr_width(OUT_SIZE);
  localparam int LANE_W = addr_width(PE_OUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_ISSUE,
    S_DRAIN
  } state_e;

endpackage

// File: rtl/pe_accum_sched_if.sv
// Configuration, PE-burst and drain-side signals of pe_accum_sched bundled
// as one interface; master is the environment, slave is the scheduler.
interface pe_accum_sched_if;
  import pe_accum_sched_pkg::*;

  logic                       cfg_valid;
  logic                       cfg_ready;
  logic [BURST_W-1:0]         cfg_bursts;
  logic                       pe_valid;
  logic                       pe_ready;
  logic [WORD_W*PE_OUT-1:0]   pe_data;
  logic [COORD_W*PE_OUT-1:0]  pe_cols;
  logic [COORD_W*PE_OUT-1:0]  pe_rows;
  logic                       out_valid;
  logic                       out_ready;
  logic [ADDR_W-1:0]          out_addr;
  logic [WORD_W-1:0]          out_data;
  logic                       out_last;
  logic                       tile_done;
  logic [DROP_W-1:0]          drop_cnt;

  modport master (
    output cfg_valid, cfg_bursts, pe_valid, pe_data, pe_cols, pe_rows, out_ready,
    input  cfg_ready, pe_ready, out_valid, out_addr, out_data, out_last,
           tile_done, drop_cnt
  );

  modport slave (
    input  cfg_valid, cfg_bursts, pe_valid, pe_data, pe_cols, pe_rows, out_ready,
    output cfg_ready, pe_ready, out_valid, out_addr, out_data, out_last,
           tile_done, drop_cnt
  );

endinterface

// File: rtl/pe_accum_sched_bank.sv
// OUT_SIZE-deep accumulation bank: one read-add-write port, one
// combinational read port and a whole-bank synchronous clear.
module accum_bank
  import pe_accum_sched_pkg::*;
(
  input  logic              tclk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WORD_W-1:0] i_wr_data,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WORD_W-1:0] o_rd_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OUT_SIZE - 1);

  logic [WORD_W-1:0] r_mem [OUT_SIZE];

  // NOTE: this bank is deliberately reset -- a reset mid-tile must discard
  // partial sums, so it is built from flops rather than an inferred RAM.
  always_ff @(posedge tclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUT_SIZE; i++) r_mem[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < OUT_SIZE; i++) r_mem[i] <= '0;
    end else if (i_wr_en && (i_wr_addr <= LAST_ADDR)) begin
      r_mem[i_wr_addr] <= r_mem[i_wr_addr] + i_wr_data;
    end
  end

  assign o_rd_data = (i_rd_addr <= LAST_ADDR) ? r_mem[i_rd_addr] : '0;

endmodule

// File: rtl/pe_accum_sched.sv
// Tile scheduler: accepts a burst count, serialises PE bursts one lane per
// cycle into the accumulation bank, then drains and clears the bank.
module pe_accum_sched
  import pe_accum_sched_pkg::*;
(
  input  logic         tclk,
  input  logic         rst,
  pe_accum_sched_if.slave bus
);

  localparam logic signed [COORD_W-1:0] C_ZERO    = '0;
  localparam logic signed [COORD_W-1:0] C_SIDE    = COORD_W'(OUT_COLS);
  localparam logic [ADDR_W-1:0]         LAST_ADDR = ADDR_W'(OUT_SIZE - 1);
  localparam logic [LANE_W-1:0]         LAST_LANE = LANE_W'(PE_OUT - 1);
  localparam logic [LANE_W-1:0]         PREV_LANE = LANE_W'(PE_OUT - 2);

  state_e                     r_state;
  logic [LANE_W-1:0]          r_lane;
  logic [BURST_W-1:0]         r_remaining;
  logic [ADDR_W-1:0]          r_idx;
  logic [WORD_W*PE_OUT-1:0]   r_data;
  logic [COORD_W*PE_OUT-1:0]  r_cols;
  logic [COORD_W*PE_OUT-1:0]  r_rows;
  logic                       r_cfg_ready;
  logic                       r_pe_ready;
  logic                       r_out_valid;
  logic                       r_tile_done;
  logic [DROP_W-1:0]          r_drop_cnt;

  logic                       w_pe_hs;
  logic                       w_last_lane;
  logic                       w_more_bursts;
  logic                       w_load;
  logic [WORD_W-1:0]          w_lane_data;
  logic signed [COORD_W-1:0]  w_col;
  logic signed [COORD_W-1:0]  w_row;
  logic                       w_in_range;
  logic [ADDR_W-1:0]          w_wr_addr;
  logic                       w_wr_en;
  logic                       w_drain_hs;
  logic                       w_drain_end;
  logic [WORD_W-1:0]          w_rd_data;

  assign w_pe_hs       = bus.pe_valid && r_pe_ready;
  assign w_last_lane   = (r_lane == LAST_LANE);
  assign w_more_bursts = (r_remaining > BURST_W'(1));
  // A burst is taken from ACCEPT, or overlapped with the last lane of the previous one.
  assign w_load        = w_pe_hs &&
                         ((r_state == S_ACCEPT) ||
                          ((r_state == S_ISSUE) && w_last_lane && w_more_bursts));

  assign w_lane_data = r_data[r_lane*WORD_W +: WORD_W];
  assign w_col       = r_cols[r_lane*COORD_W +: COORD_W];
  assign w_row       = r_rows[r_lane*COORD_W +: COORD_W];
  assign w_in_range  = (w_col >= C_ZERO) && (w_col < C_SIDE) &&
                       (w_row >= C_ZERO) && (w_row < C_SIDE);
  assign w_wr_addr   = w_col[ADDR_W-1:0] + w_row[ADDR_W-1:0] * ADDR_W'(OUT_COLS);
  assign w_wr_en     = (r_state == S_ISSUE) && w_in_range;

  assign w_drain_hs  = (r_state == S_DRAIN) && r_out_valid && bus.out_ready;
  assign w_drain_end = w_drain_hs && (r_idx == LAST_ADDR);

  accum_bank u_bank (
    .tclk      (tclk),
    .rst       (rst),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_lane_data),
    .i_clr     (w_drain_end),
    .i_rd_addr (r_idx),
    .o_rd_data (w_rd_data)
  );

  // Burst payload is pure datapath and only read after a load.
  always_ff @(posedge tclk) begin
    if (w_load) begin
      r_data <= bus.pe_data;
      r_cols <= bus.pe_cols;
      r_rows <= bus.pe_rows;
    end
  end

  // NOTE: every register below uses <= so all next-state decisions see the
  // pre-edge values; blocking assignments here would chain the updates.
  always_ff @(posedge tclk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lane      <= '0;
      r_remaining <= '0;
      r_idx       <= '0;
      r_cfg_ready <= 1'b1;
      r_pe_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_tile_done <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_tile_done <= 1'b0;
      if (w_load) r_lane <= '0;

      case (r_state)
        S_IDLE: begin
          if (bus.cfg_valid) begin
            r_cfg_ready <= 1'b0;
            r_remaining <= bus.cfg_bursts;
            r_drop_cnt  <= '0;
            r_idx       <= '0;
            if (bus.cfg_bursts == '0) begin
              r_state     <= S_DRAIN;
              r_out_valid <= 1'b1;
            end else begin
              r_state    <= S_ACCEPT;
              r_pe_ready <= 1'b1;
            end
          end
        end

        S_ACCEPT: begin
          if (w_pe_hs) begin
            r_pe_ready <= 1'b0;
            r_state    <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (!w_in_range && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
          if (!w_last_lane) begin
            r_lane <= r_lane + 1'b1;
            // Raise ready one cycle early so it is visible during the last lane.
            if ((r_lane == PREV_LANE) && w_more_bursts) r_pe_ready <= 1'b1;
          end else begin
            r_remaining <= r_remaining - 1'b1;
            if (w_more_bursts) begin
              if (w_pe_hs) r_pe_ready <= 1'b0;
              else         r_state    <= S_ACCEPT;
            end else begin
              r_state     <= S_DRAIN;
              r_pe_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_idx       <= '0;
            end
          end
        end

        S_DRAIN: begin
          if (w_drain_end) begin
            r_out_valid <= 1'b0;
            r_tile_done <= 1'b1;
            r_cfg_ready <= 1'b1;
            r_idx       <= '0;
            r_state     <= S_IDLE;
          end else if (w_drain_hs) begin
            r_idx <= r_idx + 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cfg_ready = r_cfg_ready;
  assign bus.pe_ready  = r_pe_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_addr  = r_idx;
  assign bus.out_data  = w_rd_data;
  assign bus.out_last  = r_out_valid && (r_idx == LAST_ADDR);
  assign bus.tile_done = r_tile_done;
  assign bus.drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_pe_accum_sched.sv
// Scoreboard bench for pe_accum_sched: a bank model predicts every drained
// word, which is queued at stimulus time and popped on each drain handshake.
module tb_pe_accum_sched;
  import pe_accum_sched_pkg::*;

  logic tclk = 1'b0;
  logic rst;
  always #5 tclk = ~tclk;

  pe_accum_sched_if bus ();

  pe_accum_sched dut (
    .tclk (tclk),
    .rst  (rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [WORD_W-1:0]         exp_q[$];
  logic [WORD_W-1:0]         m_bank[OUT_SIZE];
  int                        m_drop;
  logic [WORD_W-1:0]         lane_d[PE_OUT];
  logic signed [COORD_W-1:0] lane_c[PE_OUT];
  logic signed [COORD_W-1:0] lane_r[PE_OUT];

  task automatic tick();
    @(posedge tclk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < OUT_SIZE; i++) m_bank[i] = '0;
    m_drop = 0;
  endtask

  task automatic model_apply();
    for (int k = 0; k < PE_OUT; k++) begin
      int c = int'(lane_c[k]);
      int r = int'(lane_r[k]);
      if (c >= 0 && c < OUT_COLS && r >= 0 && r < OUT_COLS)
        m_bank[c + r*OUT_COLS] = m_bank[c + r*OUT_COLS] + lane_d[k];
      else if (m_drop < 65535)
        m_drop++;
    end
  endtask

  task automatic push_expect();
    for (int i = 0; i < OUT_SIZE; i++) begin
      exp_q.push_back(m_bank[i]);
      m_bank[i] = '0;
    end
  endtask

  task automatic drive_lanes();
    for (int k = 0; k < PE_OUT; k++) begin
      bus.pe_data[k*WORD_W +: WORD_W]   = lane_d[k];
      bus.pe_cols[k*COORD_W +: COORD_W] = lane_c[k];
      bus.pe_rows[k*COORD_W +: COORD_W] = lane_r[k];
    end
  endtask

  task automatic set_grid(input int scale, input int offs);
    for (int k = 0; k < PE_OUT; k++) begin
      lane_c[k] = COORD_W'(k % OUT_COLS);
      lane_r[k] = COORD_W'(k / OUT_COLS);
      lane_d[k] = WORD_W'(k*scale + offs);
    end
  endtask

  task automatic send_cfg(input int bursts);
    int t = 0;
    bus.cfg_valid  = 1'b1;
    bus.cfg_bursts = BURST_W'(bursts);
    while (!bus.cfg_ready && t < 100) begin tick(); t++; end
    n_checks++;
    if (bus.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_wait: cfg_ready got %b want 1 within 100 cycles", bus.cfg_ready);
    end
    tick();
    bus.cfg_valid = 1'b0;
    m_drop = 0;
  endtask

  task automatic send_burst(input bit last);
    int t = 0;
    drive_lanes();
    bus.pe_valid = 1'b1;
    while (!bus.pe_ready && t < 100) begin tick(); t++; end
    n_checks++;
    if (bus.pe_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pe_wait: pe_ready got %b want 1 within 100 cycles", bus.pe_ready);
    end
    tick();
    bus.pe_valid = 1'b0;
    model_apply();
    if (last) push_expect();
  endtask

  task automatic drain_check(input string name, input bit stall);
    int t   = 0;
    int idx = 0;
    int cyc = 0;
    logic [WORD_W-1:0] e;
    while (!bus.out_valid && t < 200) begin tick(); t++; end
    while (idx < OUT_SIZE && cyc < 400) begin
      bus.out_ready = stall ? (cyc % 2 == 0) : 1'b1;
      e = (exp_q.size() > 0) ? exp_q[0] : 16'hDEAD;
      n_checks += 4;
      if (bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL %s valid: out_valid got %b want 1 at word %0d", name, bus.out_valid, idx);
      end
      if (bus.out_addr !== ADDR_W'(idx)) begin
        n_fail++;
        $display("FAIL %s addr: got %0d want %0d", name, bus.out_addr, idx);
      end
      if (bus.out_data !== e) begin
        n_fail++;
        $display("FAIL %s data: addr %0d got %h want %h", name, idx, bus.out_data, e);
      end
      if (bus.out_last !== (idx == OUT_SIZE-1)) begin
        n_fail++;
        $display("FAIL %s last: addr %0d got %b want %b", name, idx, bus.out_last, idx == OUT_SIZE-1);
      end
      if (bus.out_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        idx++;
      end
      tick();
      cyc++;
    end
    bus.out_ready = 1'b0;
    n_checks += 4;
    if (idx != OUT_SIZE) begin
      n_fail++;
      $display("FAIL %s drain_count: got %0d words want %0d", name, idx, OUT_SIZE);
    end
    if (bus.tile_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s tile_done: got %b want 1", name, bus.tile_done);
    end
    if (bus.cfg_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: cfg_ready %b out_valid %b want 1 0", name, bus.cfg_ready, bus.out_valid);
    end
    if (bus.drop_cnt !== DROP_W'(m_drop)) begin
      n_fail++;
      $display("FAIL %s drop_cnt: got %0d want %0d", name, bus.drop_cnt, m_drop);
    end
    tick();
    n_checks++;
    if (bus.tile_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s tile_done_pulse: got %b want 0", name, bus.tile_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_checks += 3;
    if (bus.cfg_ready !== 1'b1 || bus.pe_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: cfg %b pe %b out_valid %b want 1 0 0",
               bus.cfg_ready, bus.pe_ready, bus.out_valid);
    end
    if (bus.out_last !== 1'b0 || bus.out_addr !== '0 || bus.out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_out: last %b addr %0d data %h want 0 0 0",
               bus.out_last, bus.out_addr, bus.out_data);
    end
    if (bus.tile_done !== 1'b0 || bus.drop_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_stat: tile_done %b drop %0d want 0 0", bus.tile_done, bus.drop_cnt);
    end
  endtask

  task automatic test_single();
    send_cfg(1);
    set_grid(1, 1);
    send_burst(1'b1);
    drain_check("single", 1'b0);
  endtask

  task automatic test_repeat();
    send_cfg(2);
    for (int k = 0; k < PE_OUT; k++) begin
      lane_c[k] = 8'sd2;
      lane_r[k] = 8'sd2;
      lane_d[k] = 16'd3;
    end
    send_burst(1'b0);
    send_burst(1'b1);
    drain_check("repeat", 1'b0);
  endtask

  task automatic test_range();
    send_cfg(1);
    for (int k = 0; k < PE_OUT; k++) begin
      case (k % 4)
        0: begin lane_c[k] = COORD_W'(k / 4); lane_r[k] = 8'sd1; lane_d[k] = WORD_W'(10 + k); end
        1: begin lane_c[k] = -8'sd1;          lane_r[k] = 8'sd0; lane_d[k] = 16'd7; end
        2: begin lane_c[k] = 8'sd0;           lane_r[k] = 8'sd5; lane_d[k] = 16'd7; end
        default: begin lane_c[k] = 8'sd5;     lane_r[k] = 8'sd0; lane_d[k] = 16'd7; end
      endcase
    end
    send_burst(1'b1);
    drain_check("range", 1'b0);
  endtask

  task automatic test_back_to_back();
    int hs[$];
    int first_ov = -1;
    send_cfg(3);
    set_grid(2, 1);
    drive_lanes();
    bus.pe_valid = 1'b1;
    for (int c = 0; c < 120; c++) begin
      if (bus.out_valid) begin first_ov = c; break; end
      if (bus.pe_ready) hs.push_back(c);
      tick();
    end
    for (int b = 0; b < 3; b++) model_apply();
    push_expect();
    n_checks++;
    if (hs.size() != 3 || first_ov < 0) begin
      n_fail++;
      $display("FAIL b2b_count: handshakes %0d want 3, first out_valid cycle %0d", hs.size(), first_ov);
    end else begin
      n_checks += 3;
      if (hs[1] - hs[0] != PE_OUT || hs[2] - hs[1] != PE_OUT) begin
        n_fail++;
        $display("FAIL b2b_spacing: gaps %0d %0d want %0d", hs[1]-hs[0], hs[2]-hs[1], PE_OUT);
      end
      if (first_ov - hs[0] - 1 != 3*PE_OUT) begin
        n_fail++;
        $display("FAIL b2b_issue_cycles: got %0d want %0d", first_ov - hs[0] - 1, 3*PE_OUT);
      end
      if (first_ov - hs[2] != PE_OUT + 1) begin
        n_fail++;
        $display("FAIL b2b_drain_start: got %0d want %0d", first_ov - hs[2], PE_OUT + 1);
      end
    end
    drain_check("b2b", 1'b0);
    bus.pe_valid = 1'b0;
  endtask

  task automatic test_zero_stall();
    send_cfg(0);
    push_expect();
    drain_check("zero", 1'b1);
  endtask

  task automatic test_wrap();
    send_cfg(1);
    for (int k = 0; k < PE_OUT; k++) begin
      lane_c[k] = -8'sd1;
      lane_r[k] = 8'sd0;
      lane_d[k] = 16'd7;
    end
    lane_c[0] = 8'sd0; lane_d[0] = 16'h7FFF;
    lane_c[1] = 8'sd0; lane_d[1] = 16'h0001;
    send_burst(1'b1);
    drain_check("wrap", 1'b0);
  endtask

  task automatic test_reset_mid();
    send_cfg(2);
    for (int k = 0; k < PE_OUT; k++) begin
      lane_c[k] = (k % 2 == 0) ? 8'sd1 : 8'sd9;
      lane_r[k] = 8'sd3;
      lane_d[k] = 16'h0101;
    end
    drive_lanes();
    bus.pe_valid = 1'b1;
    tick();
    tick();
    bus.pe_valid = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    #2;
    n_checks += 2;
    if (bus.cfg_ready !== 1'b1 || bus.pe_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_ready: cfg %b pe %b out_valid %b want 1 0 0",
               bus.cfg_ready, bus.pe_ready, bus.out_valid);
    end
    if (bus.drop_cnt !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_drop: got %0d want 0", bus.drop_cnt);
    end
    tick();
    rst = 1'b0;
    model_clear();
    tick();
    send_cfg(1);
    set_grid(3, 5);
    send_burst(1'b1);
    drain_check("rst_mid", 1'b0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.cfg_valid  = 1'b0;
    bus.cfg_bursts = '0;
    bus.pe_valid   = 1'b0;
    bus.pe_data    = '0;
    bus.pe_cols    = '0;
    bus.pe_rows    = '0;
    bus.out_ready  = 1'b0;
    model_clear();

    test_reset();
    test_single();
    test_repeat();
    test_range();
    test_back_to_back();
    test_zero_stall();
    test_wrap();
    test_reset_mid();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d words left want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
